branch_seq_ctrl: RTL
====================

Name: branch_seq_ctrl

Overview:
- Multi-cycle sequencer for branch resolution in the multi-cycle CPU.
- Accepts a branch request from the main control FSM and latches the operands.
- Evaluates the branch condition in a registered compare stage.
- If taken, computes the target and drives the PC write port through a valid/ready handshake; reports completion and outcome back to the control FSM.

Parameters:
- ADDR_W, 32, PC and operand width.
- IMM_W, 16, branch offset immediate width (word offset, sign-extended, shifted left 2).
- CNT_W, 16, width of the statistics counters (used only with BR_STATS_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- br_req  in  1  branch request valid.
- br_ready  out  1  high only in IDLE; request accepted when br_req && br_ready.
- br_op  in  4  condition code (below).
- br_usigned  in  1  unsigned compare select for LT.
- rs_val  in  ADDR_W  operand A.
- rt_val  in  ADDR_W  operand B.
- pc_plus4  in  ADDR_W  PC+4 of the branch.
- imm  in  IMM_W  signed word offset.
- pc_wr_valid  out  1  PC write request.
- pc_wr_ready  in  1  PC write accept.
- pc_wr_data  out  ADDR_W  branch target.
- br_done  out  1  one-cycle completion pulse.
- br_taken  out  1  outcome; valid while br_done=1.
- br_err  out  1  illegal br_op; valid while br_done=1.
- taken_cnt  out  CNT_W  taken-branch count (BR_STATS_EN only).
- total_cnt  out  CNT_W  resolved-branch count (BR_STATS_EN only).

Behaviour:
- Condition codes:
  - 0000 EQ: A==B.
  - 0001 NE: A!=B.
  - 1001 LT: A<B; signed, or unsigned if br_usigned=1.
  - 0100 LTZ: signed A<0.
  - 0101 GEZ: signed A>=0.
  - 0010 LEZ: signed A<=0.
  - 0011 GTZ: signed A>0.
  - Any other code is illegal: not-taken, br_err=1.
- br_usigned affects only LT. Zero-compares are always signed.
- States: IDLE, CMP, TGT, WB, DONE.
- IDLE:
  - br_ready=1.
  - On accept, latch br_op, br_usigned, rs_val, rt_val, pc_plus4, imm; go to CMP.
  - Inputs may change freely after accept.
- CMP: evaluate the condition on latched values and register cond/err.
  - Taken: go to TGT.
  - Otherwise: go to DONE.
- TGT: register target = pc_plus4 + (sign_extend(imm) << 2), modulo 2^ADDR_W (wrap, no overflow flag). Go to WB.
- WB:
  - pc_wr_valid=1; pc_wr_data holds the target and stays stable while valid.
  - Stays in WB until pc_wr_ready=1 in the same cycle, then goes to DONE.
  - pc_wr_ready outside WB is ignored.
- DONE: br_done=1 for exactly one cycle, with br_taken/br_err valid. Go to IDLE.
- Latency from accept edge:
  - Taken: br_done 4 cycles later with zero-wait ready.
  - Not-taken or illegal: br_done 2 cycles later.
- No back-to-back accept: br_ready is low from CMP through DONE. A br_req held through DONE is accepted in the following IDLE cycle.
- Reset (synchronous, rst_n=0 at a clock edge, any state including mid-WB):
  - State returns to IDLE.
  - br_ready=1.
  - pc_wr_valid, br_done, br_taken, br_err = 0.
  - pc_wr_data = 0.
  - Latched operands cleared to 0.
  - Counters cleared to 0.
  - An aborted PC write is dropped; no br_done is issued.
- Outputs are registered or decoded from state only; there is no combinational path from br_req to any output.

Optional Feature:
- Macro BR_STATS_EN.
- When defined:
  - total_cnt increments on every br_done.
  - taken_cnt increments on br_done with br_taken=1.
  - Both saturate at all-ones and never wrap.
  - Both clear on reset.
- When not defined:
  - No counter logic is built.
  - taken_cnt and total_cnt are tied to 0.

Test Plan:
- BEQ taken:
  - Stimulus: op=0000, A=B=0x1234, pc_plus4=0x00400010, imm=0x0003, pc_wr_ready=1.
  - Response: pc_wr_valid in WB with data 0x0040001C; br_done 4 cycles after accept; br_taken=1.
- LT signed vs unsigned:
  - Stimulus: op=1001, A=0xFFFFFFFF, B=0x00000001.
  - Response: usigned=0 gives taken; usigned=1 gives not-taken, br_done 2 cycles after accept, no pc_wr_valid.
- Negative offset with backpressure:
  - Stimulus: GEZ, A=0, pc_plus4=0x00000008, imm=0xFFFE, pc_wr_ready low for 3 cycles.
  - Response: pc_wr_valid held 4 cycles with data stable at 0x00000000; br_done one cycle after ready.
- Illegal op:
  - Stimulus: op=0111.
  - Response: br_done with br_err=1, br_taken=0, no PC write.
- Reset mid-WB:
  - Stimulus: rst_n=0 for 1 cycle while pc_wr_valid=1.
  - Response: next cycle pc_wr_valid=0, br_ready=1, no br_done; a following BEQ taken completes normally.
- BR_STATS_EN with CNT_W=2:
  - Stimulus: 5 taken branches.
  - Response: taken_cnt and total_cnt saturate at 3.
  - Without the macro: both read 0.

Source files
------------

// File: rtl/branch_seq_ctrl.sv
// Multi-cycle branch resolution sequencer for the multi-cycle CPU.
// Latches a branch request, evaluates the condition, computes the target
// and writes the PC through a valid/ready handshake when taken.
// Optional build macro: BR_STATS_EN enables saturating taken/total counters.
module branch_seq_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_req,
  output logic              br_ready,
  input  logic [3:0]        br_op,
  input  logic              br_usigned,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic [ADDR_W-1:0] rt_val,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [IMM_W-1:0]  imm,
  output logic              pc_wr_valid,
  input  logic              pc_wr_ready,
  output logic [ADDR_W-1:0] pc_wr_data,
  output logic              br_done,
  output logic              br_taken,
  output logic              br_err,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  total_cnt
);

  localparam logic [3:0] OP_EQ  = 4'b0000;
  localparam logic [3:0] OP_NE  = 4'b0001;
  localparam logic [3:0] OP_LEZ = 4'b0010;
  localparam logic [3:0] OP_GTZ = 4'b0011;
  localparam logic [3:0] OP_LTZ = 4'b0100;
  localparam logic [3:0] OP_GEZ = 4'b0101;
  localparam logic [3:0] OP_LT  = 4'b1001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMP,
    S_TGT,
    S_WB,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                accept_c;
  logic [3:0]          op_q;
  logic                usigned_q;
  logic [ADDR_W-1:0]   a_q;
  logic [ADDR_W-1:0]   b_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [IMM_W-1:0]    imm_q;
  logic [ADDR_W-1:0]   tgt_q;
  logic [ADDR_W-1:0]   tgt_c;
  logic                cond_c;
  logic                err_c;
  logic                a_neg_c;
  logic                a_zero_c;

  assign a_neg_c  = a_q[ADDR_W-1];
  assign a_zero_c = (a_q == '0);

  // Word offset is sign-extended and scaled to bytes; the add wraps.
  assign tgt_c = pc_q + ADDR_W'({{(ADDR_W-IMM_W){imm_q[IMM_W-1]}}, imm_q, 2'b00});

  // Branch condition decode on the latched operands
  always_comb begin
    cond_c = 1'b0;
    err_c  = 1'b0;
    case (op_q)
      OP_EQ:   cond_c = (a_q == b_q);
      OP_NE:   cond_c = (a_q != b_q);
      OP_LT:   cond_c = usigned_q ? (a_q < b_q) : ($signed(a_q) < $signed(b_q));
      OP_LTZ:  cond_c = a_neg_c;
      OP_GEZ:  cond_c = !a_neg_c;
      OP_LEZ:  cond_c = a_neg_c || a_zero_c;
      OP_GTZ:  cond_c = !a_neg_c && !a_zero_c;
      default: err_c  = 1'b1;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (br_req) begin
          accept_c  = 1'b1;
          state_nxt = S_CMP;
        end
      end
      S_CMP:   state_nxt = (cond_c && !err_c) ? S_TGT : S_DONE;
      S_TGT:   state_nxt = S_WB;
      S_WB:    if (pc_wr_ready) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Operand latch, target register and registered outputs.
  // Only taken branches pass through WB, so leaving WB marks a taken outcome;
  // the CMP->DONE exit carries the not-taken/illegal outcome.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q        <= '0;
      usigned_q   <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      tgt_q       <= '0;
      br_ready    <= 1'b1;
      pc_wr_valid <= 1'b0;
      br_done     <= 1'b0;
      br_taken    <= 1'b0;
      br_err      <= 1'b0;
    end else begin
      if (accept_c) begin
        op_q      <= br_op;
        usigned_q <= br_usigned;
        a_q       <= rs_val;
        b_q       <= rt_val;
        pc_q      <= pc_plus4;
        imm_q     <= imm;
      end
      if (state == S_TGT) tgt_q <= tgt_c;
      br_ready    <= (state_nxt == S_IDLE);
      pc_wr_valid <= (state_nxt == S_WB);
      br_done     <= (state_nxt == S_DONE);
      br_taken    <= (state_nxt == S_DONE) && (state == S_WB);
      br_err      <= (state_nxt == S_DONE) && (state == S_CMP) && err_c;
    end
  end

  assign pc_wr_data = tgt_q;

`ifdef BR_STATS_EN
  logic [CNT_W-1:0] taken_q;
  logic [CNT_W-1:0] total_q;

  // Saturating completion statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_q <= '0;
      total_q <= '0;
    end else if (br_done) begin
      if (total_q != '1)             total_q <= total_q + CNT_W'(1);
      if (br_taken && taken_q != '1) taken_q <= taken_q + CNT_W'(1);
    end
  end

  assign taken_cnt = taken_q;
  assign total_cnt = total_q;
`else
  assign taken_cnt = '0;
  assign total_cnt = '0;
`endif

endmodule
